// File: rtl/controlador_varredura_pkg.sv
// Shared encodings for the servo sweep controller: FSM states, sweep direction
// and the position endpoints.
package controlador_varredura_pkg;

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    POSICIONA = 3'd1,
    ESPERA    = 3'd2,
    MEDE      = 3'd3,
    AGUARDA   = 3'd4,
    AVANCA    = 3'd5
  } estado_t;

  typedef enum logic {
    SENT_DIR = 1'b0,
    SENT_ESQ = 1'b1
  } sentido_t;

  localparam logic [1:0] POS_MIN = 2'd0;
  localparam logic [1:0] POS_MAX = 2'd3;

endpackage

// File: rtl/contador_tempo.sv
// contador_tempo: modulo-M cycle counter with synchronous clear; fim flags the
// last count (M-1) while conta is high, so a run of M counting cycles ends on fim.
module contador_tempo #(
  parameter int M = 16
) (
  input  logic clock,
  input  logic zera_n,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] valor;

  always_ff @(posedge clock) begin
    if (!zera_n || zera)
      valor <= '0;
    else if (conta)
      valor <= (valor == W'(M - 1)) ? '0 : valor + 1'b1;
  end

  assign fim = conta && (valor == W'(M - 1));

endmodule

// File: rtl/controlador_varredura.sv
// controlador_varredura: sweeps the servo 0,1,2,3,2,1,0,... with settle/measure/advance.
// Define TIMEOUT_MEDIDA_EN to add a measurement timeout and the sticky erro_medida flag.
module controlador_varredura
  import controlador_varredura_pkg::*;
#(
  parameter int TEMPO_ASSENTAMENTO = 25_000_000,
  parameter int TEMPO_LIMITE       = 50_000_000
) (
  input  logic       clock,
  input  logic       zera_n,
  input  logic       ligar,
  input  logic       pronto_medida,
  output logic       set_pos,
  output logic [1:0] pos_inicial,
  output logic       direita,
  output logic       esquerda,
  output logic       enable_mov,
  output logic       mede,
  output logic [1:0] posicao,
  output logic       fim_varredura,
  output logic       erro_medida,
  output logic [2:0] db_estado
);

  estado_t  estado;
  sentido_t sentido;
  logic     fim_assent;
  logic     fim_limite;

  if (TEMPO_ASSENTAMENTO < 1 || TEMPO_LIMITE < 1) begin : g_param_invalido
    $error("controlador_varredura: TEMPO_ASSENTAMENTO and TEMPO_LIMITE must be >= 1");
  end

  contador_tempo #(.M(TEMPO_ASSENTAMENTO)) u_assentamento (
    .clock  (clock),
    .zera_n (zera_n),
    .zera   (estado != ESPERA),
    .conta  (estado == ESPERA),
    .fim    (fim_assent)
  );

`ifdef TIMEOUT_MEDIDA_EN
  contador_tempo #(.M(TEMPO_LIMITE)) u_limite (
    .clock  (clock),
    .zera_n (zera_n),
    .zera   (estado != AGUARDA),
    .conta  (estado == AGUARDA),
    .fim    (fim_limite)
  );
`else
  assign fim_limite  = 1'b0;
  assign erro_medida = 1'b0;
`endif

  assign pos_inicial = POS_MIN;
  assign db_estado   = estado;

  // Pulses are registered on the transition edge, so each is high exactly
  // during the first cycle of the state it belongs to.
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      estado        <= INICIAL;
      sentido       <= SENT_DIR;
      posicao       <= POS_MIN;
      set_pos       <= 1'b0;
      direita       <= 1'b0;
      esquerda      <= 1'b0;
      mede          <= 1'b0;
      fim_varredura <= 1'b0;
      enable_mov    <= 1'b0;
`ifdef TIMEOUT_MEDIDA_EN
      erro_medida   <= 1'b0;
`endif
    end else begin
      set_pos       <= 1'b0;
      direita       <= 1'b0;
      esquerda      <= 1'b0;
      mede          <= 1'b0;
      fim_varredura <= 1'b0;
      case (estado)
        INICIAL: if (ligar) begin
          estado     <= POSICIONA;
          set_pos    <= 1'b1;
          posicao    <= POS_MIN;
          sentido    <= SENT_DIR;
          enable_mov <= 1'b1;
        end
        POSICIONA: estado <= ESPERA;
        ESPERA: if (fim_assent) begin
          estado <= MEDE;
          mede   <= 1'b1;
        end
        MEDE: estado <= AGUARDA;
        AGUARDA: if (pronto_medida || fim_limite) begin
          estado        <= AVANCA;
          fim_varredura <= (sentido == SENT_DIR) ? (posicao == POS_MAX) : (posicao == POS_MIN);
`ifdef TIMEOUT_MEDIDA_EN
          if (!pronto_medida) erro_medida <= 1'b1;
`endif
        end
        AVANCA: if (!ligar) begin
          estado     <= INICIAL;
          enable_mov <= 1'b0;
        end else begin
          estado <= ESPERA;
          if (sentido == SENT_DIR) begin
            if (posicao != POS_MAX) begin
              direita <= 1'b1;
              posicao <= posicao + 2'd1;
            end else begin
              sentido  <= SENT_ESQ;
              esquerda <= 1'b1;
              posicao  <= posicao - 2'd1;
            end
          end else begin
            if (posicao != POS_MIN) begin
              esquerda <= 1'b1;
              posicao  <= posicao - 2'd1;
            end else begin
              sentido <= SENT_DIR;
              direita <= 1'b1;
              posicao <= posicao + 2'd1;
            end
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_varredura.sv
// Bench for controlador_varredura: sweep-sequence model plus directed scenarios
// (start, full sweep, graceful stop, late/missing reply, mid-run reset).
module tb_controlador_varredura;
  import controlador_varredura_pkg::*;

  localparam int TA = 4;
  localparam int TL = 10;
`ifdef TIMEOUT_MEDIDA_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0, zera_n = 1'b0, ligar = 1'b0, pronto_medida = 1'b0;
  logic set_pos, direita, esquerda, enable_mov, mede, fim_varredura, erro_medida;
  logic [1:0] pos_inicial, posicao;
  logic [2:0] db_estado;

  controlador_varredura #(.TEMPO_ASSENTAMENTO(TA), .TEMPO_LIMITE(TL)) dut (
    .clock         (clock),
    .zera_n        (zera_n),
    .ligar         (ligar),
    .pronto_medida (pronto_medida),
    .set_pos       (set_pos),
    .pos_inicial   (pos_inicial),
    .direita       (direita),
    .esquerda      (esquerda),
    .enable_mov    (enable_mov),
    .mede          (mede),
    .posicao       (posicao),
    .fim_varredura (fim_varredura),
    .erro_medida   (erro_medida),
    .db_estado     (db_estado)
  );

  always #10 clock = ~clock;

  // Model: the sweep is a sequence indexed by steps taken since the last start.
  function automatic int seq_pos(input int k);
    int r = k % 6;
    return (r <= 3) ? r : 6 - r;
  endfunction

  function automatic bit extremo(input int k);
    return seq_pos(k) == 3 || (seq_pos(k) == 0 && k > 0);
  endfunction

  estado_t m_st = INICIAL;
  int m_dw = 0, m_k = 0, cyc = 0;
  bit m_err = 1'b0;
  bit e_set = 1'b0, e_dir = 1'b0, e_esq = 1'b0, e_mede = 1'b0, e_fim = 1'b0;

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    e_set  <= 1'b0;
    e_dir  <= 1'b0;
    e_esq  <= 1'b0;
    e_mede <= 1'b0;
    e_fim  <= 1'b0;
    if (!zera_n) begin
      m_st <= INICIAL; m_dw <= 0; m_k <= 0; m_err <= 1'b0;
    end else begin
      m_dw <= m_dw + 1;
      case (m_st)
        INICIAL: if (ligar) begin m_st <= POSICIONA; m_dw <= 0; m_k <= 0; e_set <= 1'b1; end
        POSICIONA: begin m_st <= ESPERA; m_dw <= 0; end
        ESPERA: if (m_dw == TA - 1) begin m_st <= MEDE; m_dw <= 0; e_mede <= 1'b1; end
        MEDE: begin m_st <= AGUARDA; m_dw <= 0; end
        AGUARDA: if (pronto_medida || (TO_EN && m_dw == TL - 1)) begin
          m_st <= AVANCA; m_dw <= 0; e_fim <= extremo(m_k);
          if (!pronto_medida) m_err <= 1'b1;
        end
        AVANCA: begin
          m_dw <= 0;
          if (!ligar) m_st <= INICIAL;
          else begin
            m_st <= ESPERA;
            m_k  <= m_k + 1;
            if (seq_pos(m_k + 1) > seq_pos(m_k)) e_dir <= 1'b1;
            else e_esq <= 1'b1;
          end
        end
        default: m_st <= INICIAL;
      endcase
    end
  end

  int checks = 0, failures = 0;
  int n_dir = 0, n_esq = 0, n_fim = 0;

  task automatic chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, act, exp, cyc);
    end
  endtask

  task automatic compara();
    chk("set_pos", int'(set_pos), int'(e_set));
    chk("direita", int'(direita), int'(e_dir));
    chk("esquerda", int'(esquerda), int'(e_esq));
    chk("mede", int'(mede), int'(e_mede));
    chk("fim_varredura", int'(fim_varredura), int'(e_fim));
    chk("enable_mov", int'(enable_mov), int'(m_st != INICIAL));
    chk("posicao", int'(posicao), seq_pos(m_k));
    chk("erro_medida", int'(erro_medida), int'(m_err));
    chk("db_estado", int'(db_estado), int'(m_st));
    chk("pos_inicial", int'(pos_inicial), 0);
    chk("pulso_unico", int'(int'(set_pos) + int'(direita) + int'(esquerda) + int'(mede) <= 1), 1);
  endtask

  function automatic bit observa(input int qual);
    case (qual)
      0:       return set_pos;
      1:       return mede;
      default: return posicao == 2'd3 && db_estado == 3'(ESPERA);
    endcase
  endfunction

  task automatic espera(input int qual, input string nome);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (observa(qual)) return;
    end
    chk({"espera_", nome}, int'(observa(qual)), 1);
  endtask

  // Sensor reply: pronto_medida high lat cycles after the cycle mede was seen.
  task automatic responde(input int lat);
    repeat (lat) @(negedge clock);
    pronto_medida = 1'b1;
    @(negedge clock);
    pronto_medida = 1'b0;
  endtask

  initial begin
    int t0, d0, e0, f0;
    int pos_med[7];
    int esperado[7] = '{0, 1, 2, 3, 2, 1, 0};

    repeat (3) @(negedge clock);
    chk("reset_estado", int'(db_estado), 0);
    chk("reset_posicao", int'(posicao), 0);
    chk("reset_enable", int'(enable_mov), 0);
    chk("reset_erro", int'(erro_medida), 0);

    fork
      forever begin
        @(negedge clock);
        compara();
        n_dir += int'(direita);
        n_esq += int'(esquerda);
        n_fim += int'(fim_varredura);
      end
    join_none

    // Start, with a stray sensor pulse in ESPERA that must be ignored
    zera_n = 1'b1;
    ligar  = 1'b1;
    espera(0, "set_pos");
    t0 = cyc;
    @(negedge clock); pronto_medida = 1'b1;
    @(negedge clock); pronto_medida = 1'b0;
    d0 = n_dir; e0 = n_esq; f0 = n_fim;

    for (int i = 0; i < 7; i++) begin
      espera(1, "mede");
      if (i == 0) chk("latencia_mede", cyc - t0, 5);
      pos_med[i] = int'(posicao);
      if (i == 6) begin
        chk("direita_x3", n_dir - d0, 3);
        chk("esquerda_x3", n_esq - e0, 3);
        chk("fim_apos_pos3", n_fim - f0, 1);
      end
      responde(3);
    end
    repeat (2) @(negedge clock);
    chk("fim_apos_pos0", n_fim - f0, 2);
    for (int i = 0; i < 7; i++) chk($sformatf("pos_medida_%0d", i), pos_med[i], esperado[i]);

    // Graceful stop at posicao 2
    espera(1, "mede");
    responde(3);
    espera(1, "mede");
    chk("pos_parada", int'(posicao), 2);
    @(negedge clock);
    ligar = 1'b0;
    d0 = n_dir; e0 = n_esq;
    responde(2);
    @(negedge clock);
    chk("parada_estado", int'(db_estado), 0);
    chk("parada_enable", int'(enable_mov), 0);
    chk("parada_sem_passo", (n_dir - d0) + (n_esq - e0), 0);

    // Restart; reply lands in the 10th AGUARDA cycle
    ligar = 1'b1;
    espera(1, "mede");
    responde(10);
    chk("simultaneo_erro", int'(erro_medida), 0);
    chk("simultaneo_estado", int'(db_estado), 5);

    // No reply at posicao 1
    espera(1, "mede");
`ifdef TIMEOUT_MEDIDA_EN
    repeat (11) @(negedge clock);
    chk("timeout_estado", int'(db_estado), 5);
    chk("timeout_erro", int'(erro_medida), 1);
`else
    repeat (25) @(negedge clock);
    chk("sem_timeout_estado", int'(db_estado), 4);
    chk("sem_timeout_erro", int'(erro_medida), 0);
    responde(0);
`endif

    espera(1, "mede");
    chk("pos_apos_espera_longa", int'(posicao), 2);
    responde(3);
`ifdef TIMEOUT_MEDIDA_EN
    chk("erro_retido", int'(erro_medida), 1);
`else
    chk("erro_zero", int'(erro_medida), 0);
`endif

    // Mid-run reset in ESPERA at posicao 3
    espera(2, "pos3_espera");
    zera_n = 1'b0;
    @(negedge clock);
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_posicao", int'(posicao), 0);
    chk("rst_enable", int'(enable_mov), 0);
    chk("rst_pulsos", int'({set_pos, direita, esquerda, mede, fim_varredura}), 0);
    chk("rst_erro", int'(erro_medida), 0);
    zera_n = 1'b1;
    ligar  = 1'b0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
